mem_master: RTL and testbench

- Initiator for the single-port synchronous memory interface (enb, rd_wr, addr, data_in, data_out).
- Accepts burst commands (read or write, start address, length) on a valid/ready handshake.
- Sequences the per-beat memory accesses, streams write data in and read data out.
- Sits between the test/traffic logic and the memory instance; shares clk and rst_n with it.

---
 rtl/mem_master.sv | 188 ++++++++++++++++++
 tb/tb_mem_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
// Burst initiator for a single-port synchronous memory (enb/rd_wr/addr/
// data_in/data_out). A burst command (read or write, start address, beats-1)
// is taken on a valid/ready handshake. The block then walks the address range
// one beat at a time. Write data streams in on a valid/ready port, and read
// data streams out on a valid-only port.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   command handshake; cmd_rd_wr (1=read), cmd_addr, cmd_len
//   wr_valid/ready    write beat handshake, wr_data
//   rd_valid          read beat strobe (no backpressure), rd_data, rd_last
//   done              one-cycle pulse when a burst completes
//   mem_*             memory-side drive (enb, rd_wr, addr, data_in) and the
//                     registered memory output mem_data_out
// -----------------------------------------------------------------------------
module mem_master #(
    parameter int addrWidth = 9,
    parameter int dataWidth = 8,
    parameter int lenWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_rd_wr,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [lenWidth-1:0]  cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [dataWidth-1:0] wr_data,
    output logic                 rd_valid,
    output logic [dataWidth-1:0] rd_data,
    output logic                 rd_last,
    output logic                 done,
    output logic                 mem_enb,
    output logic                 mem_rd_wr,
    output logic [addrWidth-1:0] mem_addr,
    output logic [dataWidth-1:0] mem_data_in,
    input  logic [dataWidth-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   rd_valid_q;
    logic                   rd_last_q;
    logic                   done_q;
    logic [dataWidth-1:0]   rd_data_q;
    logic [addrWidth-1:0]   addr_q;
    logic [lenWidth-1:0]    beats_q;
    // Read pipeline: set for the cycle in which the memory presents the data
    // of a beat issued in the previous cycle; pipe_last_q marks the final beat.
    logic                   pipe_v_q;
    logic                   pipe_last_q;

    logic [addrWidth-1:0]   addr_d;
    logic [lenWidth-1:0]    beats_d;
    logic                   last_beat_s;

    logic                   mem_enb_s;
    logic                   mem_rd_wr_s;
    logic [dataWidth-1:0]   mem_data_in_s;
    logic                   wr_ready_s;

    // Counter steps; the address wraps naturally at 2**addrWidth.
    always_comb begin
        addr_d      = addr_q + {{(addrWidth-1){1'b0}}, 1'b1};
        beats_d     = beats_q - {{(lenWidth-1){1'b0}}, 1'b1};
        last_beat_s = (beats_q == {lenWidth{1'b0}});
    end

    // Memory-side drive; write data and enable pass straight through so a beat
    // lands in the memory in the same cycle it is accepted.
    always_comb begin
        mem_enb_s     = 1'b0;
        mem_rd_wr_s   = 1'b1;
        mem_data_in_s = {dataWidth{1'b0}};
        wr_ready_s    = 1'b0;
        case (state_q)
            WRITE: begin
                mem_enb_s     = wr_valid;
                mem_rd_wr_s   = 1'b0;
                mem_data_in_s = wr_data;
                wr_ready_s    = 1'b1;
            end
            READ: begin
                mem_enb_s   = 1'b1;
                mem_rd_wr_s = 1'b1;
            end
            default: begin
                mem_enb_s     = 1'b0;
                mem_rd_wr_s   = 1'b1;
                mem_data_in_s = {dataWidth{1'b0}};
                wr_ready_s    = 1'b0;
            end
        endcase
    end

    // Burst sequencer, counters, read pipeline and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= {dataWidth{1'b0}};
            addr_q      <= {addrWidth{1'b0}};
            beats_q     <= {lenWidth{1'b0}};
            pipe_v_q    <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            // Capture the memory output only in the cycle it is valid; the
            // last beat's strobe carries rd_last and done together.
            rd_valid_q  <= pipe_v_q;
            rd_last_q   <= pipe_v_q & pipe_last_q;
            done_q      <= pipe_v_q & pipe_last_q;
            if (pipe_v_q) begin
                rd_data_q <= mem_data_out;
            end
            pipe_v_q    <= 1'b0;
            pipe_last_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        addr_q      <= cmd_addr;
                        beats_q     <= cmd_len;
                        cmd_ready_q <= 1'b0;
                        state_q     <= cmd_rd_wr ? READ : WRITE;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        addr_q  <= addr_d;
                        beats_q <= beats_d;
                        // Write completion is reported while already idle.
                        if (last_beat_s) begin
                            state_q     <= IDLE;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    addr_q      <= addr_d;
                    beats_q     <= beats_d;
                    pipe_v_q    <= 1'b1;
                    pipe_last_q <= last_beat_s;
                    if (last_beat_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_valid_q && rd_last_q) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign wr_ready    = wr_ready_s;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_last     = rd_last_q;
    assign done        = done_q;
    assign mem_enb     = mem_enb_s;
    assign mem_rd_wr   = mem_rd_wr_s;
    assign mem_addr    = addr_q;
    assign mem_data_in = mem_data_in_s;

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
// Self-checking bench for mem_master. A behavioural single-port memory
// (registered output, resets to data = 2*addr) is attached to the DUT. A
// reference array tracks the expected memory contents; burst timing is
// derived from the cycle rules of the interface (cycle 0 = command handshake).
// -----------------------------------------------------------------------------
module tb_mem_master;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_rd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_last, done;
    logic [DW-1:0] rd_data;
    logic          mem_enb, mem_rd_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    wire  [DW-1:0] mem_data_out;

    int tests_run    = 0;
    int tests_failed = 0;
    logic hold_cmd   = 1'b0;
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] wq [$];

    always #5 clk = ~clk;

    mem_master #(.addrWidth(AW), .dataWidth(DW), .lenWidth(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
        .mem_enb(mem_enb), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Behavioural memory: registered read data, floats when not presenting data.
    logic [DW-1:0] mem_arr [2**AW];
    logic [DW-1:0] dout_q;
    logic          drive_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) mem_arr[i] <= 8'(i * 2);
            dout_q  <= 8'h00;
            drive_q <= 1'b0;
        end else begin
            drive_q <= mem_enb & mem_rd_wr;
            if (mem_enb) begin
                if (mem_rd_wr) dout_q <= mem_arr[mem_addr];
                else           mem_arr[mem_addr] <= mem_data_in;
            end
        end
    end
    assign mem_data_out = drive_q ? dout_q : 8'bz;

    function automatic void ref_reset();
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = 8'(i * 2);
    endfunction

    // Wait (bounded) for cmd_ready at a negedge, present the command, handshake.
    task automatic start_cmd(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 600) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b required 1 within %0d cycles", cmd_ready, w);
        end
        cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_addr = a; cmd_len = l;
        @(posedge clk);
        #1;
        if (!hold_cmd) cmd_valid = 1'b0;
    endtask

    // Read burst: issues in cycles 1..N, rd_valid in 3..N+2, cmd_ready back at N+3.
    task automatic test_read(input string name, input logic [AW-1:0] a, input int len);
        int n = len + 1;
        logic [AW-1:0] ea;
        logic ev, el;
        logic [DW-1:0] ed;
        start_cmd(1'b1, a, LW'(len));
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            ea = (k <= n) ? AW'(int'(a) + k - 1) : AW'(int'(a) + n);
            ev = (k >= 3) && (k <= n + 2);
            el = (k == n + 2);
            tests_run++;
            if ({mem_enb, mem_rd_wr, mem_addr, rd_valid, rd_last, done, cmd_ready, wr_ready} !==
                {(k <= n), 1'b1, ea, ev, el, el, (k == n + 3), 1'b0}) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: enb/rdwr/addr/valid/last/done/ready/wrrdy=%b/%b/%h/%b/%b/%b/%b/%b required %b/1/%h/%b/%b/%b/%b/0",
                         name, k, mem_enb, mem_rd_wr, mem_addr, rd_valid, rd_last, done, cmd_ready, wr_ready,
                         (k <= n), ea, ev, el, el, (k == n + 3));
            end
            if (ev) begin
                ed = ref_mem[AW'(int'(a) + k - 3)];
                tests_run++;
                if (rd_data !== ed) begin
                    tests_failed++;
                    $display("FAIL %s data cycle %0d: rd_data=%h required %h", name, k, rd_data, ed);
                end
            end
            // Stray write strobes during a read must be ignored.
            wr_valid = 1'($urandom);
            wr_data  = 8'($urandom);
        end
        wr_valid = 1'b0;
    endtask

    // Write burst from wq; gap_mode 0: continuous, 1: two idle cycles between beats, 2: random gaps.
    task automatic test_write(input string name, input logic [AW-1:0] a, input int len, input int gap_mode);
        int n = len + 1;
        int sent = 0;
        int cyc = 0;
        int enb_cnt = 0;
        int gap_left = 0;
        logic [AW-1:0] ea;
        start_cmd(1'b0, a, LW'(len));
        while (sent < n && cyc < 2000) begin
            cyc++;
            if (gap_left > 0) begin
                wr_valid = 1'b0; wr_data = 8'($urandom); gap_left--;
            end else begin
                wr_valid = 1'b1; wr_data = wq[sent];
            end
            @(negedge clk);
            ea = AW'(int'(a) + sent);
            tests_run++;
            if ({wr_ready, mem_enb, mem_rd_wr, mem_addr, done, cmd_ready} !== {1'b1, wr_valid, 1'b0, ea, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: wrrdy/enb/rdwr/addr/done/ready=%b/%b/%b/%h/%b/%b required 1/%b/0/%h/0/0",
                         name, cyc, wr_ready, mem_enb, mem_rd_wr, mem_addr, done, cmd_ready, wr_valid, ea);
            end
            if (wr_valid) begin
                tests_run++;
                if (mem_data_in !== wr_data) begin
                    tests_failed++;
                    $display("FAIL %s data cycle %0d: mem_data_in=%h required %h", name, cyc, mem_data_in, wr_data);
                end
            end
            if (mem_enb === 1'b1) enb_cnt++;
            @(posedge clk);
            #1;
            if (wr_valid) begin
                sent++;
                if (gap_mode == 1) gap_left = 2;
                else if (gap_mode == 2) gap_left = $urandom_range(0, 2);
            end
        end
        // Completion cycle: idle, done pulse, a stray wr_valid must be ignored.
        wr_valid = 1'b1; wr_data = 8'($urandom);
        @(negedge clk);
        tests_run++;
        if ({done, cmd_ready, mem_enb, wr_ready, mem_rd_wr, mem_data_in} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00}) begin
            tests_failed++;
            $display("FAIL %s done cycle: done/ready/enb/wrrdy/rdwr/din=%b/%b/%b/%b/%b/%h required 1/1/0/0/1/00",
                     name, done, cmd_ready, mem_enb, wr_ready, mem_rd_wr, mem_data_in);
        end
        wr_valid = 1'b0;
        tests_run++;
        if (enb_cnt != n) begin
            tests_failed++;
            $display("FAIL %s write count: %0d enables required %0d", name, enb_cnt, n);
        end
        @(negedge clk);
        tests_run++;
        if ({done, cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL %s after done: done/ready=%b/%b required 0/1", name, done, cmd_ready);
        end
        for (int i = 0; i < n; i++) ref_mem[AW'(int'(a) + i)] = wq[i];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ref_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({cmd_ready, rd_valid, rd_last, done, rd_data, mem_enb, wr_ready, mem_rd_wr, mem_addr, mem_data_in} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h000, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_values: ready/valid/last/done/data/enb/wrrdy/rdwr/addr/din=%b/%b/%b/%b/%h/%b/%b/%b/%h/%h required 0/0/0/0/00/0/0/1/000/00",
                     cmd_ready, rd_valid, rd_last, done, rd_data, mem_enb, wr_ready, mem_rd_wr, mem_addr, mem_data_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_readback();
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        test_write("write_cont", 9'h010, 3, 0);
        test_read("read_back", 9'h010, 3);
    endtask

    task automatic test_write_gaps();
        wq = '{8'hA5, 8'h5A, 8'hC3};
        test_write("write_gaps", 9'h040, 2, 1);
        test_read("read_gaps", 9'h040, 2);
    endtask

    task automatic test_wrap();
        wq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        test_write("write_wrap", 9'h1FE, 3, 0);
        test_read("read_wrap", 9'h1FE, 3);
    endtask

    // Command held valid through a busy burst: accepted again only once idle.
    task automatic test_busy_cmd();
        hold_cmd = 1'b1;
        test_read("busy_first", 9'h012, 7);
        hold_cmd = 1'b0;
        test_read("busy_second", 9'h012, 7);
    endtask

    task automatic test_reset_mid_burst();
        start_cmd(1'b1, 9'h100, 8'd7);
        repeat (3) @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_pre: rd_valid=%b required 1", rd_valid);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        ref_reset();
        #1;
        tests_run++;
        if ({rd_valid, rd_last, done, mem_enb, cmd_ready, rd_data} !== {5'b00000, 8'h00}) begin
            tests_failed++;
            $display("FAIL midreset_assert: valid/last/done/enb/ready/data=%b/%b/%b/%b/%b/%h required 0/0/0/0/0/00",
                     rd_valid, rd_last, done, mem_enb, cmd_ready, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 5; k <= 14; k++) begin
            @(negedge clk);
            tests_run++;
            if ({rd_valid, done, mem_enb, cmd_ready} !== 4'b0001) begin
                tests_failed++;
                $display("FAIL midreset_after cycle %0d: valid/done/enb/ready=%b/%b/%b/%b required 0/0/0/1",
                         k, rd_valid, done, mem_enb, cmd_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int len;
        for (int it = 0; it < 8; it++) begin
            a   = AW'($urandom_range(0, 2**AW - 1));
            len = $urandom_range(0, 15);
            if ((it % 2) == 0) begin
                wq.delete();
                for (int i = 0; i <= len; i++) wq.push_back(8'($urandom));
                test_write("rand_write", a, len, 2);
            end else begin
                test_read("rand_read", a, len);
            end
        end
        test_read("rand_long", 9'h1F0, 255);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rst_n = 1'b0;
        test_reset();
        test_read("single_read", 9'h005, 0);
        test_write_readback();
        test_write_gaps();
        test_wrap();
        test_busy_cmd();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
